// File: rtl/rep_udec_pkg.sv
// Shared types and width helpers for the unary-to-binary decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rep_udec_pkg;

    // Default geometry: 8-bit result from a 256-sample window.
    localparam int DEF_BITWIDTH = 8;
    localparam int DEF_WINLOG   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ones counter must hold 0..2^WINLOG inclusive, hence one extra bit.
    function automatic int cntWidth(input int winLog);
        return winLog + 1;
    endfunction

    // Left shift that maps a window count onto the full binary range.
    function automatic int shiftAmt(input int bitWidth, input int winLog);
        return bitWidth - winLog;
    endfunction

    // Largest representable result; bitWidth is expected to stay below 32.
    function automatic int satMax(input int bitWidth);
        return (1 << bitWidth) - 1;
    endfunction

endpackage

// File: rtl/rep_udec_wincnt.sv
// Enabled sample counter for one decode window, with synchronous clear.
// Latency: count updates at the edge after iEn; oTc is combinational.
// Backpressure: none; iEn low simply holds the count.
//
// Ports:
//   iClk, iRst : clock, asynchronous active-high reset
//   iClr       : synchronous clear to zero (wins over iEn)
//   iEn        : count one sample this cycle
//   oTc        : this enabled sample is the last one of the window
module rep_udec_wincnt #(
    parameter int WIDTH = 8
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iClr,
    input  logic iEn,
    output logic oTc
);

    logic [WIDTH-1:0] cnt;

    // Natural wrap at the terminal count re-arms the counter for the next
    // window, so no explicit clear is needed on completion.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt <= '0;
        end else if (iClr) begin
            cnt <= '0;
        end else if (iEn) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign oTc = iEn && (cnt == {WIDTH{1'b1}});

endmodule

// File: rtl/rep_udec.sv
// Unary-to-binary decoder: counts ones over 2^WINLOG enabled samples, scales to BITWIDTH bits.
// Latency: oBin/oValid registered at the final-sample edge (visible the following cycle).
// Backpressure: none; oValid is a single-cycle pulse the consumer must capture.
//
// Ports:
//   iClk, iRst : clock, asynchronous active-high reset
//   iStart     : begin a window (honoured in IDLE only)
//   iEn        : sample enable; iBit is counted only in RUN with iEn high
//   iClr       : synchronous abort, priority over iStart and completion
//   iBit       : unary bitstream
//   oBin       : last completed result, held until the next completion
//   oValid     : one-cycle pulse marking a new oBin
//   oBusy      : high while a window is in progress
//
// Build option: REP_UDEC_CONTINUOUS_EN keeps the block in RUN after each
// window so back-to-back windows decode without a restart or gap cycle.
module rep_udec
    import rep_udec_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int WINLOG   = DEF_WINLOG
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iBit,
    output logic [BITWIDTH-1:0] oBin,
    output logic                oValid,
    output logic                oBusy
);

    localparam int                CW      = cntWidth(WINLOG);
    localparam int                SHIFT   = shiftAmt(BITWIDTH, WINLOG);
    localparam logic [BITWIDTH-1:0] SAT_MAX = BITWIDTH'(satMax(BITWIDTH));

    state_t         state;
    state_t         stateNxt;
    logic           cntClr;
    logic           cntEn;
    logic           winTc;
    logic           winDone;
    logic [CW-1:0]  onesCnt;
    logic [CW-1:0]  total;
    logic [BITWIDTH:0]   scaled;
    logic [BITWIDTH-1:0] binNxt;

    rep_udec_wincnt #(
        .WIDTH (WINLOG)
    ) uWinCnt (
        .iClk (iClk),
        .iRst (iRst),
        .iClr (cntClr),
        .iEn  (cntEn),
        .oTc  (winTc)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        cntClr   = 1'b0;
        cntEn    = 1'b0;
        winDone  = 1'b0;
        case (state)
            IDLE: begin
                if (iClr) begin
                    cntClr = 1'b1;
                end else if (iStart) begin
                    stateNxt = RUN;
                    cntClr   = 1'b1;
                end
            end
            RUN: begin
                if (iClr) begin
                    stateNxt = IDLE;
                    cntClr   = 1'b1;
                end else begin
                    cntEn = iEn;
                    if (winTc) begin
                        winDone = 1'b1;
`ifdef REP_UDEC_CONTINUOUS_EN
                        stateNxt = RUN;
`else
                        stateNxt = IDLE;
`endif
                    end
                end
            end
            default: begin
                stateNxt = IDLE;
                cntClr   = 1'b1;
            end
        endcase
    end

    // Ones counter restarts on window entry, abort, and completion; the
    // completion restart is what lets continuous mode start the next window
    // on the very next enabled sample.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            onesCnt <= '0;
        end else if (cntClr || winDone) begin
            onesCnt <= '0;
        end else if (cntEn) begin
            onesCnt <= onesCnt + CW'(iBit);
        end
    end

    // total is at most 2^WINLOG, so after scaling the only overflow case is
    // exactly 2^BITWIDTH (all-ones window), flagged by the top bit.
    assign total  = onesCnt + CW'(iBit);
    assign scaled = (BITWIDTH + 1)'(total) << SHIFT;
    assign binNxt = scaled[BITWIDTH] ? SAT_MAX : scaled[BITWIDTH-1:0];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oBin   <= '0;
            oValid <= 1'b0;
        end else begin
            oValid <= winDone;
            if (winDone) begin
                oBin <= binNxt;
            end
        end
    end

    assign oBusy = (state == RUN);

endmodule

// File: doc/rep_udec.md
# rep_udec

Unary-to-binary bitstream decoder: counts 1s in a rate-coded unary bitstream over a fixed window of 2^WINLOG enabled samples and presents the result as a BITWIDTH-bit binary value. It sits downstream of the unary multiplier array and converts product bitstreams back to binary for readout or accumulation. The multiplier side encodes binary to unary; this block performs the inverse.

## Interface

- BITWIDTH, 8: width of the binary result.
- WINLOG, 8: log2 of window length in enabled samples; legal range 1..BITWIDTH.

- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  asynchronous, active-high reset. Decided: one clock; reset is asynchronous and active-high.
- iStart  input  1  starts a window. Honoured only in IDLE.
- iEn  input  1  sample enable; iBit is counted only in RUN with iEn=1.
- iClr  input  1  synchronous abort/clear.
- iBit  input  1  unary bitstream input.
- oBin  output  BITWIDTH  decoded result; holds its value until the next completed window.
- oValid  output  1  one-cycle pulse marking a new oBin.
- oBusy  output  1  high while in RUN.

## Operation

- States:
  - IDLE (reset state).
  - RUN.
- Transitions:
  - IDLE→RUN on iStart=1, iClr=0.
  - RUN→IDLE on iClr=1.
  - RUN→IDLE on the window's final enabled sample.
- Registers:
  - sample counter: WINLOG bits.
  - ones counter: WINLOG+1 bits.
  - Both are cleared on entry to RUN.
- In RUN with iEn=1:
  - sample counter increments.
  - ones counter adds iBit.
  - With iEn=0, both counters hold; the window stretches.
- Final sample (sample counter = 2^WINLOG−1, iEn=1):
  - total = ones + iBit.
  - oBin <= min(total << (BITWIDTH−WINLOG), 2^BITWIDTH−1).
  - An all-ones window saturates to 2^BITWIDTH−1.
  - oValid <= 1 for exactly one cycle.
- iStart while in RUN is ignored.
- iClr, from any state:
  - counters cleared, state → IDLE, oValid <= 0.
  - oBin is retained.
  - iClr has priority over iStart and over window completion in the same cycle.
- iRst:
  - Asserted mid-window: immediate abort, no oValid.
  - Reset values: state IDLE, oBin=0, oValid=0, oBusy=0, counters 0.

## Timing

- iStart sampled at edge t0 → oBusy=1 after t0; the first sample is counted at edge t0+1.
- No iEn gaps: oValid is high in the cycle following edge t0+2^WINLOG, together with the new oBin.
- Latency from the final sample edge to oValid/oBin is 0 cycles: both are registered at that edge.
- Single-shot mode: oBusy falls at the same edge oValid rises. A new iStart is accepted in that same cycle.
- oBin changes only at a window-completion edge or on iRst.

## Configuration

- REP_UDEC_CONTINUOUS_EN defined:
  - On the final sample, the block stays in RUN.
  - Counters reset and the next window starts on the next enabled sample, with no gap cycle.
  - oBusy stays high and oValid pulses once per window.
  - Only iClr or iRst return the block to IDLE.
- REP_UDEC_CONTINUOUS_EN undefined: single-shot behaviour as in Operation; each window needs its own iStart.

## Structure

- Package rep_udec_pkg:
  - State enum (IDLE, RUN).
  - Width helper constants: count width = WINLOG+1, shift amount = BITWIDTH−WINLOG.
  - Saturation maximum.
- Sub-module rep_udec_wincnt:
  - WINLOG-bit enabled sample counter with synchronous clear.
  - Terminal-count output (count = max and iEn).
  - Instantiated once.
- Top level holds the FSM, ones counter, scaling/saturation and output registers.

## Test plan

- Reset: assert iRst mid-stream → oBin=0, oValid=0, oBusy=0; no oValid after release without iStart.
- BITWIDTH=8, WINLOG=8, iStart, iEn=1, iBit=1 for 256 cycles → oBin=255 (saturated); a single oValid pulse in the cycle after the 256th sample edge; oBusy=0.
- iBit alternating 1,0 for 256 enabled samples → oBin=128; then all-zero window → oBin=0.
- iEn with low gaps: 256 enabled samples spread over 300 cycles, 64 ones on enabled cycles plus ones on disabled cycles → oBin=64; oValid only after the 256th enabled sample.
- iClr at enabled sample 100, with a previous oBin=128 → no oValid, oBin stays 128, oBusy=0 next cycle; iClr+iStart together stays IDLE; a subsequent fresh window yields its own count only.
- WINLOG=4, BITWIDTH=8: 16 samples with 5 ones → oBin=80. With REP_UDEC_CONTINUOUS_EN, windows of 0 then 3 ones → oValid pulses 16 cycles apart with oBin=0 then 48, oBusy held high.
